mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory (MEM) stage of the SCHOLAR RISC-V pipeline. It consumes the EXE->MEM payload (ALU result, store data, rd, memory and GPR controls) under the EXE/MEM valid/ready handshake. It performs loads and stores on the data-memory request/grant/response bus and presents a registered writeback payload to WB. It drives the back-pressure (`ready_o`) that EXE uses as its `mem_ready_i`.

Parameters:
ADDR_WIDTH, 32, width of dmem_addr_o; taken from exe_out_i[ADDR_WIDTH-1:0]

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
exe_valid_i  in  1  EXE payload valid
ready_o  out  1  MEM can accept a payload this cycle (to EXE mem_ready_i)
exe_out_i  in  32  ALU result: memory address, or GPR result for non-memory ops
op3_i  in  32  store data
rd_i  in  5  destination register
mem_ctrl_i  in  4  0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; 9-15 treated as NOP
gpr_we_i  in  1  GPR write enable
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 store, 0 load
dmem_addr_o  out  ADDR_WIDTH  word-aligned address (low 2 bits zero)
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  32  store data, lane-replicated
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response (load data or store ack)
dmem_rdata_i  in  32  load data
wb_ready_i  in  1  WB consumes output this cycle
valid_o  out  1  writeback payload valid
wb_data_o  out  32  writeback value
wb_rd_o  out  5  writeback rd
wb_we_o  out  1  GPR write enable
misalign_o  out  1  access was misaligned; no bus access was made

Behaviour:
- Reset (async, rst_i=1): state IDLE; dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0; valid_o=0, wb_data_o=0, wb_rd_o=0, wb_we_o=0, misalign_o=0.
  - Reset mid-transaction abandons it. The bus is reset in the same domain.
- Output register is a single entry: valid_o holds with payload stable until valid_o && wb_ready_i; it then clears unless refilled that same cycle.
- ready_o = (state==IDLE) && (!valid_o || wb_ready_i). Combinational; independent of exe_valid_i.
- Accept = exe_valid_i && ready_o.
- Accept of a non-memory op (ctrl NOP/9-15):
  - next cycle valid_o=1, wb_data_o=exe_out_i, wb_rd_o=rd_i, wb_we_o=gpr_we_i.
  - Latency 1; back-to-back at full rate.
- Accept of a misaligned op (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - no bus request.
  - next cycle valid_o=1, misalign_o=1, wb_we_o=0, wb_data_o=exe_out_i.
- Accept of an aligned memory op: latch request fields; go to REQ.
- State REQ:
  - dmem_req_o=1; addr, we, be and wdata stable until grant.
  - On dmem_gnt_i=1: go to WAIT; dmem_req_o=0 next cycle.
- State WAIT:
  - dmem_rvalid_i arrives at least one cycle after gnt; rvalid in the same cycle as gnt is a protocol violation.
  - On rvalid: load the output register and go to IDLE.
  - Loads: wb_we_o=gpr_we_i. Stores: wb_we_o=0, wb_data_o=exe_out_i.
- The output register is always empty during REQ/WAIT, because accept required it free.
- Store formatting, with lane L = addr[1:0]:
  - SB: be=1<<L; wdata = byte replicated ×4.
  - SH: be=3<<(2*addr[1]); wdata = half replicated ×2.
  - SW: be=4'hF; wdata=op3_i.
- Load formatting:
  - LB/LBU: rdata[8L+7:8L], sign/zero-extended to 32.
  - LH/LHU: rdata[16*addr[1]+15:16*addr[1]], sign/zero-extended.
  - LW: rdata.
  - Loads drive be as for stores of the same size.
- Best-case load latency: accept N, req+gnt N+1, rvalid N+2, valid_o N+3.
- misalign_o=0 for all non-misaligned results.

Test Plan:
- Non-memory op: exe_out_i=0x1234, rd=5, gpr_we=1, wb_ready=1, one per cycle for 4 cycles -> ready_o stays 1; each payload appears on valid_o/wb_data_o one cycle later, in order.
- LBU at addr 0x103, rdata=0x80FF_7F01, gnt immediate, rvalid 2 cycles later -> be=4'b1000, addr=0x100, wb_data=0x0000_0080; LB on the same data -> 0xFFFF_FF80; ready_o=0 from REQ until return to IDLE.
- SH at 0x202 with op3=0xABCD_1234, gnt delayed 3 cycles -> req/addr/be/wdata stable: addr=0x200, be=4'b1100, wdata=0x1234_1234; after rvalid, valid_o=1 with wb_we=0.
- LW at 0x301 -> no dmem_req_o; next cycle valid_o=1, misalign_o=1, wb_we=0.
- Back-pressure: valid_o=1 with wb_ready=0 for 5 cycles -> ready_o=0, output stable. When wb_ready=1 with a new exe_valid, the new payload is accepted in the same cycle and there is no bubble.
- Assert rst_i during WAIT of a load -> all outputs at reset values immediately (async); after release, ready_o=1; a stale rvalid is ignored in IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage: memory stage of the SCHOLAR RISC-V pipeline.
//
// Accepts the EXE->MEM payload under a valid/ready handshake. Performs loads
// and stores on a request/grant/response data bus, and presents a single-entry
// registered writeback payload to WB.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   exe_valid_i/ready_o   EXE handshake; ready_o feeds EXE mem_ready_i
//   exe_out_i             ALU result (memory address or GPR result)
//   op3_i                 store data
//   rd_i, gpr_we_i        destination register and its write enable
//   mem_ctrl_i            0 NOP,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW, else NOP
//   dmem_*                data-memory bus (req/gnt, then rvalid response)
//   wb_ready_i/valid_o    WB handshake
//   wb_data_o, wb_rd_o, wb_we_o, misalign_o   writeback payload
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // EXE -> MEM
  input  logic                  exe_valid_i,
  output logic                  ready_o,
  input  logic [31:0]           exe_out_i,
  input  logic [31:0]           op3_i,
  input  logic [4:0]            rd_i,
  input  logic [3:0]            mem_ctrl_i,
  input  logic                  gpr_we_i,
  // Data-memory bus
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [31:0]           dmem_rdata_i,
  // MEM -> WB
  input  logic                  wb_ready_i,
  output logic                  valid_o,
  output logic [31:0]           wb_data_o,
  output logic [4:0]            wb_rd_o,
  output logic                  wb_we_o,
  output logic                  misalign_o
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  // Access size encoding
  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  state_e r_state;
  state_e w_state_nxt;

  // Bus request registers
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;

  // Context of the in-flight access, needed when the response returns
  logic        r_is_load;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic        r_gpr_we;
  logic [31:0] r_exe_out;

  // Output register
  logic        r_valid;
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we;
  logic        r_misalign;

  logic        w_valid_nxt;
  logic [31:0] w_wb_data_nxt;
  logic [4:0]  w_wb_rd_nxt;
  logic        w_wb_we_nxt;
  logic        w_misalign_nxt;

  // Decode
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_unsigned;
  logic [1:0]  w_size;
  logic        w_misalign;
  logic        w_accept;
  logic        w_start_bus;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_resp;
  logic [31:0] w_load_data;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_unsigned = 1'b0;
    w_size     = SzWord;
    unique case (mem_ctrl_i)
      4'd1: begin w_is_load  = 1'b1; w_size = SzByte; end
      4'd2: begin w_is_load  = 1'b1; w_size = SzHalf; end
      4'd3: begin w_is_load  = 1'b1; w_size = SzWord; end
      4'd4: begin w_is_load  = 1'b1; w_size = SzByte; w_unsigned = 1'b1; end
      4'd5: begin w_is_load  = 1'b1; w_size = SzHalf; w_unsigned = 1'b1; end
      4'd6: begin w_is_store = 1'b1; w_size = SzByte; end
      4'd7: begin w_is_store = 1'b1; w_size = SzHalf; end
      4'd8: begin w_is_store = 1'b1; w_size = SzWord; end
      default: ;
    endcase
  end

  assign w_is_mem   = w_is_load | w_is_store;
  assign w_misalign = w_is_mem &&
                      (((w_size == SzHalf) && exe_out_i[0]) ||
                       ((w_size == SzWord) && (exe_out_i[1:0] != 2'b00)));

  // Can only take a new payload when idle and the output slot is (or becomes) free
  assign ready_o     = (r_state == StIdle) && (!r_valid || wb_ready_i);
  assign w_accept    = exe_valid_i && ready_o;
  assign w_start_bus = w_accept && w_is_mem && !w_misalign;
  assign w_resp      = (r_state == StWait) && dmem_rvalid_i;

  // Byte enables are shared by loads and stores of the same size
  always_comb begin
    unique case (w_size)
      SzByte:  w_be = 4'b0001 << exe_out_i[1:0];
      SzHalf:  w_be = exe_out_i[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Store data is lane-replicated so the memory only needs the byte enables
  always_comb begin
    w_wdata = 32'h0;
    if (w_is_store) begin
      unique case (w_size)
        SzByte:  w_wdata = {4{op3_i[7:0]}};
        SzHalf:  w_wdata = {2{op3_i[15:0]}};
        default: w_wdata = op3_i;
      endcase
    end
  end

  // Load extraction and extension
  always_comb begin
    unique case (r_lane)
      2'd0:    w_rbyte = dmem_rdata_i[7:0];
      2'd1:    w_rbyte = dmem_rdata_i[15:8];
      2'd2:    w_rbyte = dmem_rdata_i[23:16];
      default: w_rbyte = dmem_rdata_i[31:24];
    endcase
    w_rhalf = r_lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    unique case (r_size)
      SzByte:  w_load_data = {{24{w_rbyte[7] & ~r_unsigned}}, w_rbyte};
      SzHalf:  w_load_data = {{16{w_rhalf[15] & ~r_unsigned}}, w_rhalf};
      default: w_load_data = dmem_rdata_i;
    endcase
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_start_bus)   w_state_nxt = StReq;
      StReq:   if (dmem_gnt_i)    w_state_nxt = StWait;
      StWait:  if (dmem_rvalid_i) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Request fields are captured once at accept and held until grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'h0;
      r_wdata    <= 32'h0;
      r_is_load  <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SzByte;
      r_lane     <= 2'd0;
      r_rd       <= 5'd0;
      r_gpr_we   <= 1'b0;
      r_exe_out  <= 32'h0;
    end else if (w_start_bus) begin
      r_we       <= w_is_store;
      r_addr     <= {exe_out_i[ADDR_WIDTH-1:2], 2'b00};
      r_be       <= w_be;
      r_wdata    <= w_wdata;
      r_is_load  <= w_is_load;
      r_unsigned <= w_unsigned;
      r_size     <= w_size;
      r_lane     <= exe_out_i[1:0];
      r_rd       <= rd_i;
      r_gpr_we   <= gpr_we_i;
      r_exe_out  <= exe_out_i;
    end
  end

  // Output register next state. The slot is empty during REQ/WAIT, so an
  // accept and a bus response can never collide.
  always_comb begin
    w_valid_nxt    = r_valid;
    w_wb_data_nxt  = r_wb_data;
    w_wb_rd_nxt    = r_wb_rd;
    w_wb_we_nxt    = r_wb_we;
    w_misalign_nxt = r_misalign;
    if (r_valid && wb_ready_i) w_valid_nxt = 1'b0;
    if (w_accept && !w_start_bus) begin
      // Non-memory op or misaligned access: completes without the bus
      w_valid_nxt    = 1'b1;
      w_wb_data_nxt  = exe_out_i;
      w_wb_rd_nxt    = rd_i;
      w_wb_we_nxt    = w_misalign ? 1'b0 : gpr_we_i;
      w_misalign_nxt = w_misalign;
    end else if (w_resp) begin
      w_valid_nxt    = 1'b1;
      w_wb_data_nxt  = r_is_load ? w_load_data : r_exe_out;
      w_wb_rd_nxt    = r_rd;
      w_wb_we_nxt    = r_is_load ? r_gpr_we : 1'b0;
      w_misalign_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid    <= 1'b0;
      r_wb_data  <= 32'h0;
      r_wb_rd    <= 5'd0;
      r_wb_we    <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_wb_data  <= w_wb_data_nxt;
      r_wb_rd    <= w_wb_rd_nxt;
      r_wb_we    <= w_wb_we_nxt;
      r_misalign <= w_misalign_nxt;
    end
  end

  assign dmem_req_o   = (r_state == StReq);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_be_o    = r_be;
  assign dmem_wdata_o = r_wdata;

  assign valid_o    = r_valid;
  assign wb_data_o  = r_wb_data;
  assign wb_rd_o    = r_wb_rd;
  assign wb_we_o    = r_wb_we;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, hand-written multi-cycle
// sequences and randomized transactions against a behavioural model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        exe_valid;
  logic        ready;
  logic [31:0] exe_out;
  logic [31:0] op3;
  logic [4:0]  rd;
  logic [3:0]  ctrl;
  logic        gwe;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        wb_ready;
  logic        valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        mis;

  int n_total = 0;
  int n_bad   = 0;

  mem_stage #(.ADDR_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .exe_valid_i  (exe_valid),
    .ready_o      (ready),
    .exe_out_i    (exe_out),
    .op3_i        (op3),
    .rd_i         (rd),
    .mem_ctrl_i   (ctrl),
    .gpr_we_i     (gwe),
    .dmem_req_o   (req),
    .dmem_we_o    (we),
    .dmem_addr_o  (addr),
    .dmem_be_o    (be),
    .dmem_wdata_o (wdata),
    .dmem_gnt_i   (gnt),
    .dmem_rvalid_i(rvalid),
    .dmem_rdata_i (rdata),
    .wb_ready_i   (wb_ready),
    .valid_o      (valid),
    .wb_data_o    (wb_data),
    .wb_rd_o      (wb_rd),
    .wb_we_o      (wb_we),
    .misalign_o   (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got=%h want=%h", tag, nm, act, exp);
    end
  endtask

  // Reference: derives the expected bus and writeback from the ISA rules
  function automatic void ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d,
                                    input logic [31:0] rdv, input logic g,
                                    output bit bus, output logic [3:0] ebe,
                                    output logic [31:0] ewd, output bit est,
                                    output logic [31:0] ewb, output logic ewe, output logic emis);
    int unsigned size;
    int unsigned off;
    bit ld;
    bit sgn;
    logic [31:0] v;
    logic [31:0] mask;
    size = 0;
    if (c == 1 || c == 4 || c == 6) size = 1;
    if (c == 2 || c == 5 || c == 7) size = 2;
    if (c == 3 || c == 8) size = 4;
    ld   = (c >= 1 && c <= 5);
    est  = (c >= 6 && c <= 8);
    sgn  = (c == 1 || c == 2);
    off  = a % 4;
    bus  = 1'b0;
    ebe  = 4'h0;
    ewd  = 32'h0;
    ewb  = a;
    emis = 1'b0;
    ewe  = g;
    if (size != 0) begin
      if (off % size != 0) begin
        emis = 1'b1;
        ewe  = 1'b0;
      end else begin
        bus = 1'b1;
        ebe = 4'(((1 << size) - 1) << off);
        if (size == 1) ewd = (d & 32'hFF) * 32'h0101_0101;
        else if (size == 2) ewd = (d & 32'hFFFF) * 32'h0001_0001;
        else ewd = d;
        if (ld) begin
          v = rdv >> (8 * off);
          if (size < 4) begin
            mask = 32'((64'd1 << (8 * size)) - 1);
            v = v & mask;
            if (sgn && v[8*size-1]) v = v | ~mask;
          end
          ewb = v;
        end else begin
          ewe = 1'b0;
        end
      end
    end
  endfunction

  // One complete transaction; starts and ends idle with the output slot empty
  task automatic do_txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rdv, input logic [4:0] r,
                        input logic g, input int gdly, input int rdly, input int stall,
                        input bit ebus, input logic [3:0] ebe, input logic [31:0] ewd,
                        input bit est, input logic [31:0] ewb, input logic ewe,
                        input logic emis);
    exe_valid = 1'b1; ctrl = c; exe_out = a; op3 = d; rd = r; gwe = g;
    #1 chk(tag, "ready_idle", 32'(ready), 32'd1);
    tick();
    exe_valid = 1'b0;
    if (ebus) begin
      chk(tag, "ready_busy", 32'(ready), 32'd0);
      for (int k = 0; k <= gdly; k++) begin
        chk(tag, "req", 32'(req), 32'd1);
        chk(tag, "addr", addr, a & 32'hFFFF_FFFC);
        chk(tag, "be", 32'(be), 32'(ebe));
        chk(tag, "we", 32'(we), 32'(est));
        if (est) chk(tag, "wdata", wdata, ewd);
        if (k < gdly) tick();
      end
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk(tag, "req_drop", 32'(req), 32'd0);
      for (int k = 0; k < rdly; k++) begin
        chk(tag, "wait_valid", 32'(valid), 32'd0);
        tick();
      end
      rvalid = 1'b1; rdata = rdv;
      tick();
      rvalid = 1'b0; rdata = $urandom;
    end else begin
      chk(tag, "no_req", 32'(req), 32'd0);
    end
    chk(tag, "valid", 32'(valid), 32'd1);
    chk(tag, "wb_data", wb_data, ewb);
    chk(tag, "wb_rd", 32'(wb_rd), 32'(r));
    chk(tag, "wb_we", 32'(wb_we), 32'(ewe));
    chk(tag, "misalign", 32'(mis), 32'(emis));
    for (int k = 0; k < stall; k++) begin
      tick();
      chk(tag, "stall_ready", 32'(ready), 32'd0);
      chk(tag, "stall_data", wb_data, ewb);
    end
    wb_ready = 1'b1;
    #1 chk(tag, "ready_drain", 32'(ready), 32'd1);
    tick();
    wb_ready = 1'b0;
    chk(tag, "drained", 32'(valid), 32'd0);
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdv;
    int          gdly;
    int          rdly;
    bit          ebus;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    bit          est;
    logic [31:0] ewb;
    logic        ewe;
    logic        emis;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit          m_bus;
    bit          m_st;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    logic [31:0] m_wb;
    logic        m_we;
    logic        m_mis;
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rdd;
    logic [31:0] rrd;
    logic        rg;

    //            ctrl  addr          op3           rdata         gd rd bus be      wdata         st wb            we   mis
    vecs[0]  = '{4'd4, 32'h103,      32'h0,        32'h80FF_7F01, 0, 1, 1, 4'b1000, 32'h0,        0, 32'h0000_0080, 1'b1, 1'b0};
    vecs[1]  = '{4'd1, 32'h103,      32'h0,        32'h80FF_7F01, 0, 1, 1, 4'b1000, 32'h0,        0, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[2]  = '{4'd2, 32'h102,      32'h0,        32'h80FF_7F01, 1, 0, 1, 4'b1100, 32'h0,        0, 32'hFFFF_80FF, 1'b1, 1'b0};
    vecs[3]  = '{4'd5, 32'h100,      32'h0,        32'h80FF_7F01, 0, 2, 1, 4'b0011, 32'h0,        0, 32'h0000_7F01, 1'b1, 1'b0};
    vecs[4]  = '{4'd3, 32'h104,      32'h0,        32'hDEAD_BEEF, 2, 0, 1, 4'b1111, 32'h0,        0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[5]  = '{4'd6, 32'h201,      32'h1234_56A5, 32'h0,        0, 0, 1, 4'b0010, 32'hA5A5_A5A5, 1, 32'h0000_0201, 1'b0, 1'b0};
    vecs[6]  = '{4'd7, 32'h202,      32'hABCD_1234, 32'h0,        3, 1, 1, 4'b1100, 32'h1234_1234, 1, 32'h0000_0202, 1'b0, 1'b0};
    vecs[7]  = '{4'd8, 32'h20C,      32'hCAFE_F00D, 32'h0,        0, 1, 1, 4'b1111, 32'hCAFE_F00D, 1, 32'h0000_020C, 1'b0, 1'b0};
    vecs[8]  = '{4'd3, 32'h301,      32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        0, 32'h0000_0301, 1'b0, 1'b1};
    vecs[9]  = '{4'd7, 32'h203,      32'h1111,     32'h0,         0, 0, 0, 4'b0000, 32'h0,        0, 32'h0000_0203, 1'b0, 1'b1};
    vecs[10] = '{4'd5, 32'h101,      32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        0, 32'h0000_0101, 1'b0, 1'b1};
    vecs[11] = '{4'd0, 32'h1234,     32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        0, 32'h0000_1234, 1'b1, 1'b0};
    vecs[12] = '{4'd12, 32'h55AA,    32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        0, 32'h0000_55AA, 1'b1, 1'b0};
    vecs[13] = '{4'd1, 32'h100,      32'h0,        32'h0000_007F, 0, 0, 1, 4'b0001, 32'h0,        0, 32'h0000_007F, 1'b1, 1'b0};

    rst = 1'b1; exe_valid = 1'b0; exe_out = 32'h0; op3 = 32'h0; rd = 5'd0; ctrl = 4'd0;
    gwe = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; wb_ready = 1'b0;
    #1;
    chk("reset", "req", 32'(req), 32'd0);
    chk("reset", "be", 32'(be), 32'd0);
    chk("reset", "addr", addr, 32'd0);
    chk("reset", "wdata", wdata, 32'd0);
    chk("reset", "valid", 32'(valid), 32'd0);
    chk("reset", "wb_data", wb_data, 32'd0);
    chk("reset", "ready", 32'(ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].d, vecs[i].rdv, 5'(i + 1),
             1'b1, vecs[i].gdly, vecs[i].rdly, (i % 3), vecs[i].ebus, vecs[i].ebe, vecs[i].ewd,
             vecs[i].est, vecs[i].ewb, vecs[i].ewe, vecs[i].emis);
    end

    // Non-memory ops at full rate
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exe_valid = 1'b1; ctrl = 4'd0; exe_out = 32'h1234 + 32'(i); rd = 5'd5; gwe = 1'b1;
      #1 chk("b2b", "ready", 32'(ready), 32'd1);
      tick();
      chk("b2b", "valid", 32'(valid), 32'd1);
      chk("b2b", "wb_data", wb_data, 32'h1234 + 32'(i));
    end
    exe_valid = 1'b0;
    tick();
    chk("b2b", "empty", 32'(valid), 32'd0);

    // Back-pressure, then same-cycle drain and refill
    exe_valid = 1'b1; ctrl = 4'd0; exe_out = 32'hAAAA_0001; rd = 5'd7; gwe = 1'b1;
    tick();
    wb_ready = 1'b0; exe_out = 32'hBBBB_0002; rd = 5'd8;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp", "ready", 32'(ready), 32'd0);
      chk("bp", "hold", wb_data, 32'hAAAA_0001);
      tick();
    end
    chk("bp", "hold_rd", 32'(wb_rd), 32'd7);
    wb_ready = 1'b1;
    #1 chk("bp", "ready_refill", 32'(ready), 32'd1);
    tick();
    exe_valid = 1'b0;
    chk("bp", "refill_valid", 32'(valid), 32'd1);
    chk("bp", "refill_data", wb_data, 32'hBBBB_0002);
    tick();
    wb_ready = 1'b0;
    chk("bp", "empty", 32'(valid), 32'd0);

    // Reset while waiting for a load response
    exe_valid = 1'b1; ctrl = 4'd3; exe_out = 32'h400; rd = 5'd3; gwe = 1'b1;
    tick();
    exe_valid = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstw", "req", 32'(req), 32'd0);
    chk("rstw", "addr", addr, 32'd0);
    chk("rstw", "be", 32'(be), 32'd0);
    chk("rstw", "we", 32'(we), 32'd0);
    chk("rstw", "valid", 32'(valid), 32'd0);
    tick();
    rst = 1'b0;
    chk("rstw", "ready", 32'(ready), 32'd1);
    rvalid = 1'b1; rdata = 32'h1357_9BDF;
    tick();
    rvalid = 1'b0;
    chk("rstw", "stale", 32'(valid), 32'd0);
    chk("rstw", "ready2", 32'(ready), 32'd1);

    // Randomized transactions against the model
    for (int i = 0; i < 200; i++) begin
      rc  = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rdd = $urandom;
      rrd = $urandom;
      rg  = 1'($urandom_range(0, 1));
      ref_model(rc, ra, rdd, rrd, rg, m_bus, m_be, m_wd, m_st, m_wb, m_we, m_mis);
      do_txn($sformatf("rnd%0d", i), rc, ra, rdd, rrd, 5'($urandom_range(0, 31)), rg,
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
             m_bus, m_be, m_wd, m_st, m_wb, m_we, m_mis);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
